// File: rtl/conv_stream_encoder.sv
// conv_stream_encoder
//   Front conv + ReLU stage of the encoder. Buffers one raster-order frame,
//   then for every strided output position runs a KxK convolution on CH
//   channels in parallel. Each channel has one MAC that is reused over K*K
//   cycles. Every result gets its bias added, is saturated, and optionally
//   passes through ReLU.
// Ports
//   clk_p               : clock, rising edge
//   reset               : synchronous, active-low
//   in_data/in_valid    : pixel stream in
//   in_ready            : high while the frame is being loaded
//   weights             : CH*K*K signed taps, index ch*K*K + ky*K + kx
//   biases              : CH signed biases
//   out_data            : CH signed results for one output position
//   out_row/out_col     : position of out_data
//   out_valid/out_ready : result handshake
//   frame_done          : one-cycle pulse after the last result is taken
module conv_stream_encoder #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 10,
  parameter int IMG_W  = 10,
  parameter int IMG_H  = 10,
  parameter int K      = 3,
  parameter int STRIDE = 2,
  parameter int CH     = 16,
  parameter int RELU   = 1,
  localparam int OUT_W = (IMG_W - K) / STRIDE + 1,
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1,
  localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic                             clk_p,
  input  logic                             reset,
  input  logic [DATA_W-1:0]                in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CH*K*K-1:0][DATA_W-1:0]    weights,
  input  logic [CH-1:0][DATA_W-1:0]        biases,
  output logic [CH-1:0][DATA_W-1:0]        out_data,
  output logic [ROW_W-1:0]                 out_row,
  output logic [COL_W-1:0]                 out_col,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             frame_done
);

  localparam int NPIX   = IMG_W * IMG_H;
  localparam int ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int KW     = (K > 1) ? $clog2(K) : 1;
  localparam int WIDX_W = (CH * K * K > 1) ? $clog2(CH * K * K) : 1;
  // Wide enough that K*K full-scale products plus the shifted bias never overflow
  localparam int ACC_W  = 2 * DATA_W + $clog2(K * K) + 1;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
  localparam logic [KW-1:0]     LAST_K   = KW'(K - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(OUT_H - 1);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(OUT_W - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_OUTPUT  = 2'd2
  } state_e;

  // Drop the fraction (floor), saturate to DATA_W, then optionally clamp negatives
  function automatic logic [DATA_W-1:0] finish_result(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shifted;
    logic [DATA_W-1:0]       res;
    shifted = acc >>> FRAC_W;
    if (shifted > SAT_MAX) begin
      res = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      res = SAT_MIN[DATA_W-1:0];
    end else begin
      res = shifted[DATA_W-1:0];
    end
    if ((RELU != 0) && res[DATA_W-1]) begin
      res = {DATA_W{1'b0}};
    end else begin
      res = res;
    end
    return res;
  endfunction

  logic [DATA_W-1:0]             fb_q [NPIX];
  state_e                        state_q, state_d;
  logic [ADDR_W-1:0]             pix_cnt_q, pix_cnt_d;
  logic [KW-1:0]                 ky_q, ky_d, kx_q, kx_d;
  logic [ROW_W-1:0]              row_q, row_d;
  logic [COL_W-1:0]              col_q, col_d;
  logic signed [ACC_W-1:0]       acc_q [CH];
  logic signed [ACC_W-1:0]       acc_d [CH];
  logic [CH-1:0][DATA_W-1:0]     out_data_q, out_data_d;
  logic                          in_ready_q, in_ready_d;
  logic                          out_valid_q, out_valid_d;
  logic                          frame_done_q, frame_done_d;
  logic                          fb_we;
  logic [ADDR_W-1:0]             pix_addr;
  logic [DATA_W-1:0]             pix_val;
  logic [WIDX_W-1:0]             widx [CH];
  logic signed [2*DATA_W-1:0]    prod [CH];
  logic                          first_tap, last_tap, last_pos;

  assign pix_addr  = ADDR_W'((int'(row_q) * STRIDE + int'(ky_q)) * IMG_W
                             + int'(col_q) * STRIDE + int'(kx_q));
  assign pix_val   = fb_q[pix_addr];
  assign first_tap = (ky_q == KW'(0)) && (kx_q == KW'(0));
  assign last_tap  = (ky_q == LAST_K) && (kx_q == LAST_K);
  assign last_pos  = (row_q == LAST_ROW) && (col_q == LAST_COL);

  // Per-channel product of the current tap pixel with that channel's weight
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      widx[c] = WIDX_W'(c * K * K + int'(ky_q) * K + int'(kx_q));
      prod[c] = $signed(pix_val) * $signed(weights[widx[c]]);
    end
  end

  // Next-state, counter, accumulator and output-register logic
  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    ky_d         = ky_q;
    kx_d         = kx_q;
    row_d        = row_q;
    col_d        = col_q;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;
    fb_we        = 1'b0;
    for (int c = 0; c < CH; c++) begin
      acc_d[c] = acc_q[c];
    end
    case (state_q)
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          fb_we = 1'b1;
          if (pix_cnt_q == LAST_PIX) begin
            state_d   = S_COMPUTE;
            pix_cnt_d = ADDR_W'(0);
            ky_d      = KW'(0);
            kx_d      = KW'(0);
            row_d     = ROW_W'(0);
            col_d     = COL_W'(0);
          end else begin
            pix_cnt_d = pix_cnt_q + ADDR_W'(1);
          end
        end else begin
          fb_we = 1'b0;
        end
      end
      S_COMPUTE: begin
        // Tap 0 restarts the sum from the bias, aligned to the product's fraction
        for (int c = 0; c < CH; c++) begin
          acc_d[c] = (first_tap ? ($signed({{(ACC_W-DATA_W){biases[c][DATA_W-1]}}, biases[c]}) <<< FRAC_W)
                                : acc_q[c])
                   + $signed({{(ACC_W-2*DATA_W){prod[c][2*DATA_W-1]}}, prod[c]});
        end
        if (last_tap) begin
          state_d = S_OUTPUT;
          ky_d    = KW'(0);
          kx_d    = KW'(0);
          for (int c = 0; c < CH; c++) begin
            out_data_d[c] = finish_result(acc_d[c]);
          end
        end else if (kx_q == LAST_K) begin
          kx_d = KW'(0);
          ky_d = ky_q + KW'(1);
        end else begin
          kx_d = kx_q + KW'(1);
        end
      end
      S_OUTPUT: begin
        if (out_valid_q && out_ready) begin
          if (last_pos) begin
            state_d      = S_LOAD;
            row_d        = ROW_W'(0);
            col_d        = COL_W'(0);
            pix_cnt_d    = ADDR_W'(0);
            frame_done_d = 1'b1;
          end else if (col_q == LAST_COL) begin
            state_d = S_COMPUTE;
            col_d   = COL_W'(0);
            row_d   = row_q + ROW_W'(1);
          end else begin
            state_d = S_COMPUTE;
            col_d   = col_q + COL_W'(1);
          end
        end else begin
          state_d = S_OUTPUT;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
    // Handshake flags are registered from the next state so they align with it
    in_ready_d  = (state_d == S_LOAD);
    out_valid_d = (state_d == S_OUTPUT);
  end

  // State, counters, accumulators and registered outputs
  always_ff @(posedge clk_p) begin
    if (!reset) begin
      state_q      <= S_LOAD;
      pix_cnt_q    <= ADDR_W'(0);
      ky_q         <= KW'(0);
      kx_q         <= KW'(0);
      row_q        <= ROW_W'(0);
      col_q        <= COL_W'(0);
      out_data_q   <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        acc_q[c] <= ACC_W'(0);
      end
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      ky_q         <= ky_d;
      kx_q         <= kx_d;
      row_q        <= row_d;
      col_q        <= col_d;
      out_data_q   <= out_data_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      for (int c = 0; c < CH; c++) begin
        acc_q[c] <= acc_d[c];
      end
    end
  end

  // Frame buffer write port; contents deliberately survive reset
  always_ff @(posedge clk_p) begin
    if (fb_we) begin
      fb_q[pix_cnt_q] <= in_data;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_row    = row_q;
  assign out_col    = col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_stream_encoder.sv
// Bench for conv_stream_encoder: a RELU=1 and a RELU=0 instance share all inputs.
module tb_conv_stream_encoder;

  localparam int DATA_W = 16;
  localparam int IMG_W  = 10;
  localparam int IMG_H  = 10;
  localparam int K      = 3;
  localparam int STRIDE = 2;
  localparam int CH     = 16;
  localparam int OUT_W  = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H  = (IMG_H - K) / STRIDE + 1;
  localparam int NPOS   = OUT_W * OUT_H;
  localparam int NPIX   = IMG_W * IMG_H;

  logic                          clk_p = 1'b0;
  logic                          reset;
  logic [DATA_W-1:0]             in_data;
  logic                          in_valid;
  logic                          in_ready, in_ready_nr;
  logic [CH*K*K-1:0][DATA_W-1:0] weights;
  logic [CH-1:0][DATA_W-1:0]     biases;
  logic [CH-1:0][DATA_W-1:0]     out_data, out_data_nr;
  logic [1:0]                    out_row, out_row_nr;
  logic [1:0]                    out_col, out_col_nr;
  logic                          out_valid, out_valid_nr;
  logic                          out_ready;
  logic                          frame_done, frame_done_nr;

  always #5 clk_p = ~clk_p;

  conv_stream_encoder #(.RELU(1)) dut (
    .clk_p(clk_p), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .weights(weights), .biases(biases), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_valid(out_valid),
    .out_ready(out_ready), .frame_done(frame_done));

  conv_stream_encoder #(.RELU(0)) dut_nr (
    .clk_p(clk_p), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_nr), .weights(weights), .biases(biases), .out_data(out_data_nr),
    .out_row(out_row_nr), .out_col(out_col_nr), .out_valid(out_valid_nr),
    .out_ready(out_ready), .frame_done(frame_done_nr));

  int checks   = 0;
  int failures = 0;
  int fd_cnt   = 0;
  int overlap_cnt = 0;

  typedef struct {
    string       name;
    logic [15:0] pix;
    logic [15:0] wgt;
    logic [15:0] bias;
    logic [15:0] exp_relu;
    logic [15:0] exp_norelu;
  } vec_t;

  vec_t vecs [8];

  // Count frame_done pulses and any cycle with in_ready and out_valid both high
  always @(negedge clk_p) begin
    if (frame_done) fd_cnt = fd_cnt + 1;
    if (in_ready && out_valid) overlap_cnt = overlap_cnt + 1;
  end

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [CH*DATA_W-1:0] act,
                           input logic [CH*DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_uniform_params(input logic [15:0] w, input logic [15:0] b);
    for (int i = 0; i < CH*K*K; i++) weights[i] = w;
    for (int i = 0; i < CH; i++) biases[i] = b;
  endtask

  // mode 0: every pixel = val; mode 1: pixel i = i. Starts and ends 1 time unit after an edge.
  task automatic load_frame(input int mode, input logic [15:0] val, input bit gaps);
    int i;
    int cyc;
    bit take;
    i = 0;
    cyc = 0;
    while (i < NPIX && cyc < NPIX*4 + 50) begin
      take = !(gaps && ($urandom_range(0, 2) == 0));
      in_valid = take;
      in_data = !take ? 16'hDEAD : ((mode == 0) ? val : 16'(i));
      take = take && in_ready;
      @(posedge clk_p); #1;
      if (take) i++;
      cyc++;
    end
    in_valid = 1'b0;
    check_int("load_count", i, NPIX);
  endtask

  task automatic run_positions(input int n_pos, input bit ramp, input logic [15:0] er,
                               input logic [15:0] enr, input bit stall);
    for (int p = 0; p < n_pos; p++) begin
      int r;
      int c;
      int wait_cyc;
      logic [CH*DATA_W-1:0] exp_r;
      logic [CH*DATA_W-1:0] exp_nr;
      r = p / OUT_W;
      c = p % OUT_W;
      wait_cyc = 0;
      while (!out_valid && wait_cyc < 50) begin
        @(posedge clk_p); #1;
        wait_cyc++;
      end
      check_int("latency", wait_cyc, K*K);
      if (ramp) begin
        exp_r = '0;
        exp_r[15:0] = 16'((r*STRIDE + 1) * IMG_W + c*STRIDE + 1);
        exp_nr = exp_r;
      end else begin
        exp_r  = {CH{er}};
        exp_nr = {CH{enr}};
      end
      check_int("out_row", out_row, r);
      check_int("out_col", out_col, c);
      check_vec("data_relu", out_data, exp_r);
      check_vec("data_norelu", out_data_nr, exp_nr);
      if (stall && p == 0) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(posedge clk_p); #1;
          check_int("stall_valid", out_valid, 1);
          check_vec("stall_data", out_data, exp_r);
          check_int("stall_col", out_col, 0);
        end
        out_ready = 1'b1;
      end
      @(posedge clk_p); #1;
      if (p == NPOS - 1) begin
        check_int("frame_done_pulse", frame_done, 1);
        check_int("in_ready_after_frame", in_ready, 1);
        check_int("out_valid_after_frame", out_valid, 0);
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_int({tag, "_in_ready"}, in_ready, 1);
    check_int({tag, "_out_valid"}, out_valid, 0);
    check_int({tag, "_frame_done"}, frame_done, 0);
    check_vec({tag, "_out_data"}, out_data, '0);
    check_vec({tag, "_out_data_nr"}, out_data_nr, '0);
  endtask

  initial begin
    int fd0;
    vecs[0] = '{"unity",      16'h0400, 16'h0400, 16'h0000, 16'h2400, 16'h2400};
    vecs[1] = '{"neg_w",      16'h0400, 16'hFC00, 16'h0000, 16'h0000, 16'hDC00};
    vecs[2] = '{"neg_w_bias", 16'h0400, 16'hFC00, 16'h2800, 16'h0400, 16'h0400};
    vecs[3] = '{"sat_pos",    16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF};
    vecs[4] = '{"sat_neg",    16'h7FFF, 16'h8001, 16'h0000, 16'h0000, 16'h8000};
    vecs[5] = '{"neg_pix",    16'hFC00, 16'h0200, 16'h0064, 16'h0000, 16'hEE64};
    vecs[6] = '{"floor_neg",  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF};
    vecs[7] = '{"neg_bias",   16'h0200, 16'h0100, 16'hFF00, 16'h0380, 16'h0380};

    reset = 1'b0;
    in_valid = 1'b0;
    in_data = 16'h0000;
    out_ready = 1'b1;
    set_uniform_params(16'h0000, 16'h0000);
    repeat (2) @(posedge clk_p);
    #1;
    check_reset_state("reset");
    reset = 1'b1;

    for (int v = 0; v < 8; v++) begin
      set_uniform_params(vecs[v].wgt, vecs[v].bias);
      fd0 = fd_cnt;
      load_frame(0, vecs[v].pix, 1'b0);
      run_positions(NPOS, 1'b0, vecs[v].exp_relu, vecs[v].exp_norelu, 1'b0);
      repeat (3) @(posedge clk_p);
      #1;
      check_int({vecs[v].name, "_frame_done_count"}, fd_cnt - fd0, 1);
    end

    // Ramp frame, centre tap of channel 0 only; then the same with random input gaps
    set_uniform_params(16'h0000, 16'h0000);
    weights[4] = 16'h0400;
    load_frame(1, 16'h0000, 1'b0);
    run_positions(NPOS, 1'b1, 16'h0000, 16'h0000, 1'b0);
    load_frame(1, 16'h0000, 1'b1);
    run_positions(NPOS, 1'b1, 16'h0000, 16'h0000, 1'b0);

    // Output back-pressure at (0,0)
    set_uniform_params(16'h0400, 16'h0000);
    load_frame(0, 16'h0400, 1'b0);
    run_positions(NPOS, 1'b0, 16'h2400, 16'h2400, 1'b1);

    // Reset while computing position (2,1), then a fresh frame
    load_frame(0, 16'h0400, 1'b0);
    run_positions(9, 1'b0, 16'h2400, 16'h2400, 1'b0);
    repeat (3) @(posedge clk_p);
    #1;
    reset = 1'b0;
    @(posedge clk_p);
    #1;
    reset = 1'b1;
    check_reset_state("midreset");
    fd0 = fd_cnt;
    load_frame(0, 16'h0400, 1'b0);
    run_positions(NPOS, 1'b0, 16'h2400, 16'h2400, 1'b0);
    repeat (3) @(posedge clk_p);
    #1;
    check_int("after_reset_frame_done_count", fd_cnt - fd0, 1);
    check_int("ready_valid_overlap", overlap_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_stream_encoder.md
# conv_stream_encoder

Parametrised streaming convolution encoder stage. It accepts one image frame as a raster-order pixel stream over a valid/ready handshake and buffers the frame. It then computes a strided KxK convolution for CH output channels in parallel, reusing one MAC per channel over K*K cycles per output position. Each position's result passes through bias, saturation and optional ReLU, and is emitted as a CH-wide vector over a valid/ready handshake. It is the front (conv + relu) layer of the encoder, replacing the fixed stride-2 conv block ahead of the dense layer.

## Interface
- DATA_W, 16, pixel/weight/bias/output width, signed fixed point
- FRAC_W, 10, fractional bits (Q6.10 at defaults)
- IMG_W, 10, frame width in pixels
- IMG_H, 10, frame height in pixels
- K, 3, square kernel size
- STRIDE, 2, convolution stride, both axes
- CH, 16, output channels
- RELU, 1, 1 = clamp negatives to 0; 0 = pass signed result
- Derived: OUT_W = (IMG_W-K)/STRIDE+1, OUT_H = (IMG_H-K)/STRIDE+1; 4x4 at defaults.

Ports:
- clk_p, in, 1, the single clock; all logic on its rising edge
- reset, in, 1, synchronous, active-low
- in_data, in, DATA_W signed, pixel
- in_valid, in, 1, pixel valid
- in_ready, out, 1, block accepts pixel
- weights, in, [CH*K*K] x DATA_W signed, index ch*K*K + ky*K + kx; stable during a frame
- biases, in, [CH] x DATA_W signed; stable during a frame
- out_data, out, [CH] x DATA_W signed, one result per channel
- out_row, out, $clog2(OUT_H), output position row
- out_col, out, $clog2(OUT_W), output position column
- out_valid, out, 1, result valid
- out_ready, in, 1, consumer accepts
- frame_done, out, 1, single-cycle pulse after the last result is accepted

## Operation
- FSM: LOAD -> COMPUTE -> OUTPUT -> (COMPUTE for the next position | LOAD after the last position).
- LOAD:
  - in_ready = 1.
  - Each cycle with in_valid & in_ready writes the pixel to frame buffer address pix_cnt, then increments pix_cnt.
  - Gaps in in_valid are allowed.
  - The cycle that accepts pixel IMG_W*IMG_H-1 transitions to COMPUTE, with position (0,0) and tap 0.
- Frame buffer: IMG_W*IMG_H register array with combinational read.
- COMPUTE:
  - in_ready = 0; in_valid is ignored.
  - Tap t = 0..K*K-1 with ky = t/K and kx = t%K.
  - Pixel address = (out_row*STRIDE+ky)*IMG_W + out_col*STRIDE+kx.
  - Per channel c: acc_c = (t==0 ? sext(biases[c]) <<< FRAC_W : acc_c) + pixel*weights[c*K*K+t].
  - The cycle with t = K*K-1 transitions to OUTPUT.
- Arithmetic:
  - Products are 2*DATA_W bits.
  - Accumulator is 2*DATA_W + $clog2(K*K) + 1 bits; no overflow possible.
  - Result = acc >>> FRAC_W (arithmetic shift, floor), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - If RELU = 1, negative results become 0.
  - Each result is registered into out_data on entry to OUTPUT.
- OUTPUT:
  - out_valid = 1; out_data, out_row and out_col are held stable until out_valid & out_ready.
  - On the handshake: advance out_col, wrapping to 0 and incrementing out_row at OUT_W-1, then return to COMPUTE.
  - On the handshake at (OUT_H-1, OUT_W-1): go to LOAD, clear pix_cnt, and pulse frame_done on the next cycle, when in_ready is already 1.
- Reset (reset == 0 at a clock edge), from any state including mid-LOAD, mid-COMPUTE or mid-OUTPUT:
  - State goes to LOAD; pix_cnt, tap, out_row, out_col clear.
  - in_ready = 1 from the first cycle after reset; out_valid = 0, frame_done = 0, out_data = 0.
  - Frame buffer contents are not cleared and are don't-care.

## Timing
- Pixel acceptance: 1 per cycle max; minimum LOAD time is IMG_W*IMG_H cycles.
- Last pixel accepted at cycle n -> first COMPUTE tap at n+1 -> out_valid high at n+1+K*K.
- Per position: K*K compute cycles plus at least 1 OUTPUT cycle. Minimum frame compute is OUT_W*OUT_H*(K*K+1) cycles, 160 at defaults.
- out_valid never drops without a handshake or reset.
- in_ready and out_valid are never high in the same cycle.

## Test plan
- Uniform frame: all pixels 1024 (1.0), all weights 1024, biases 0 -> all 16 positions, all channels = 9216; frame_done pulses once.
- Ramp frame: pixel i = i (raw 0..99); channel 0 uses only the centre weight = 1024, other weights 0 -> ch0 at (0,0) = 11, (0,3) = 17, (3,3) = 77; other channels 0.
- ReLU and bias: pixels 1024, weights -1024, bias 0 -> RELU=1 gives 0, RELU=0 gives -9216; with bias 10240 -> 1024 in both builds.
- Saturation: pixels 32767, weights 32767 -> 32767; weights -32767 with RELU=0 -> -32768.
- Handshake:
  - Hold out_ready low 5 cycles at (0,0) -> out_valid, out_data and out_col stay stable, then advance to (0,1).
  - Random in_valid gaps -> results identical to the gap-free run.
- Reset mid-COMPUTE of (2,1) -> next cycle out_valid 0 and in_ready 1; a fresh uniform frame then yields 9216 at all positions.
